// File: rtl/ks_accum32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ks_pkg
//  Description : Shared constants and FSM state encoding for the ks_accum32
//                serial-lane accumulator.
//                  N      - adder lane width in bits
//                  ACC_W  - accumulator width (two lanes)
//                  state_t- accumulator FSM states
//  Revision    : 1.0 - initial release
// ============================================================================
package ks_pkg;

    localparam int N     = 16;
    localparam int ACC_W = 2 * N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD_LO = 2'd1,
        ADD_HI = 2'd2,
        RESULT = 2'd3
    } state_t;

endpackage : ks_pkg
`default_nettype wire

// File: rtl/ks_accum32_if.sv
`default_nettype none
// ============================================================================
//  Module      : ks_accum32_if
//  Description : Operand / result handshake bundle for ks_accum32.
//                  in_valid/in_ready/in_data/in_last - operand channel
//                  clear                             - synchronous abort
//                  out_valid/out_ready/out_sum/out_ovf - result channel
//                master modport: upstream/downstream side (drives operands)
//                slave modport : the accumulator itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface ks_accum32_if;
    import ks_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, clear, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, clear, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

endinterface : ks_accum32_if
`default_nettype wire

// File: rtl/ks_accum32_kogge.sv
`default_nettype none
// ============================================================================
//  Module      : Kogge
//  Description : 16-bit Kogge-Stone parallel-prefix adder with carry-in.
//                  a_i, b_i - addends
//                  cin_i    - carry-in
//                  sum_o    - 16-bit sum
//                  cout_o   - carry-out of bit 15
//  Revision    : 1.0 - initial release
// ============================================================================
module Kogge (
    input  wire logic [15:0] a_i,
    input  wire logic [15:0] b_i,
    input  wire logic        cin_i,
    output logic      [15:0] sum_o,
    output logic             cout_o
);

    localparam int WIDTH  = 16;
    localparam int LEVELS = 4;

    logic [WIDTH-1:0] w_p0;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g_nxt;
    logic [WIDTH-1:0] w_p_nxt;

    always_comb begin
        w_p0 = a_i ^ b_i;
        // Fold carry-in into bit 0's generate so the prefix tree yields the
        // carry into every bit directly as the group generate below it.
        w_g    = a_i & b_i;
        w_g[0] = (a_i[0] & b_i[0]) | (w_p0[0] & cin_i);
        w_p    = w_p0;
        w_g_nxt = w_g;
        w_p_nxt = w_p;
        for (int l = 0; l < LEVELS; l++) begin
            w_g_nxt = w_g;
            w_p_nxt = w_p;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l)) begin
                    w_g_nxt[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                    w_p_nxt[i] = w_p[i] & w_p[i - (1 << l)];
                end
            end
            w_g = w_g_nxt;
            w_p = w_p_nxt;
        end
        sum_o  = w_p0 ^ {w_g[WIDTH-2:0], cin_i};
        cout_o = w_g[WIDTH-1];
    end

endmodule : Kogge
`default_nettype wire

// File: rtl/ks_accum32.sv
`default_nettype none
// ============================================================================
//  Module      : ks_accum32
//  Description : 32-bit unsigned accumulator built around a single 16-bit
//                Kogge-Stone adder used twice per operand (low lane, then
//                high lane with the registered lane carry).
//                  clk   - clock, all state changes on rising edge
//                  rst_n - asynchronous active-low reset
//                  bus   - ks_accum32_if.slave: operand channel
//                          (in_valid/in_ready/in_data/in_last), clear,
//                          result channel (out_valid/out_ready/out_sum/
//                          out_ovf)
//  Revision    : 1.0 - initial release
// ============================================================================
module ks_accum32 #(
    parameter int N     = ks_pkg::N,
    parameter int ACC_W = 2 * N
) (
    input wire logic   clk,
    input wire logic   rst_n,
    ks_accum32_if.slave bus
);
    import ks_pkg::*;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [N-1:0]     opnd_q,  opnd_d;
    logic             c_lo_q,  c_lo_d;
    logic             last_q,  last_d;
    logic             ovf_q,   ovf_d;

    logic [N-1:0]     w_add_a;
    logic [N-1:0]     w_add_b;
    logic             w_add_cin;
    logic [N-1:0]     w_add_sum;
    logic             w_add_cout;
    logic             w_in_ready;
    logic             w_accept;

    // Adder operand mux: low lane + operand in ADD_LO, high lane + lane
    // carry in ADD_HI. Other states leave the low-lane selection idle.
    always_comb begin
        w_add_a   = acc_q[N-1:0];
        w_add_b   = opnd_q;
        w_add_cin = 1'b0;
        if (state_q == ADD_HI) begin
            w_add_a   = acc_q[ACC_W-1:N];
            w_add_b   = '0;
            w_add_cin = c_lo_q;
        end
    end

    Kogge u_kogge (
        .a_i    (w_add_a),
        .b_i    (w_add_b),
        .cin_i  (w_add_cin),
        .sum_o  (w_add_sum),
        .cout_o (w_add_cout)
    );

    // rst_n gates in_ready so nothing is offered while reset is held,
    // even though the state register already sits in IDLE.
    assign w_in_ready = rst_n && (state_q == IDLE) && !bus.clear;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        c_lo_d  = c_lo_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            c_lo_d  = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        opnd_d  = bus.in_data;
                        last_d  = bus.in_last;
                        state_d = ADD_LO;
                    end
                end
                ADD_LO: begin
                    acc_d[N-1:0] = w_add_sum;
                    c_lo_d       = w_add_cout;
                    state_d      = ADD_HI;
                end
                ADD_HI: begin
                    acc_d[ACC_W-1:N] = w_add_sum;
                    ovf_d            = ovf_q | w_add_cout;
                    state_d          = last_q ? RESULT : IDLE;
                end
                RESULT: begin
                    if (bus.out_ready) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            opnd_q  <= '0;
            c_lo_q  <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            c_lo_q  <= c_lo_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (state_q == RESULT) && !bus.clear;
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;

endmodule : ks_accum32
`default_nettype wire

// File: tb/tb_ks_accum32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ks_accum32
//  Description : Directed self-checking bench for ks_accum32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ks_accum32;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errs;

    ks_accum32_if bus ();

    ks_accum32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #4000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one operand and hold it until accepted; returns on the falling
    // edge after the accepting rising edge (DUT then in ADD_LO).
    task automatic send(input logic [15:0] d, input logic l);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        #1;
        while (bus.in_ready !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (t >= 10) begin
            errs++;
            $error("FAIL send_timeout observed=in_ready_low expected=accept");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int t;
        t = 0;
        while (bus.out_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            errs++;
            $error("FAIL result_timeout observed=out_valid_low expected=out_valid_high");
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("drain_valid", bus.out_valid, 1'b0);
        chk("drain_sum",   bus.out_sum,   32'h0);
        chk("drain_ovf",   bus.out_ovf,   1'b0);
        chk("drain_ready", bus.in_ready,  1'b1);
    endtask

    initial begin
        vectors       = 0;
        errs          = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  bus.in_ready,  1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_sum",       bus.out_sum,   32'h0);
        chk("rst_ovf",       bus.out_ovf,   1'b0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        // Single last operand, latency of 3 cycles
        send(16'h0005, 1'b1);
        chk("lat1_valid", bus.out_valid, 1'b0);
        chk("lat1_ready", bus.in_ready,  1'b0);
        @(negedge clk);
        chk("lat2_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("lat3_valid", bus.out_valid, 1'b1);
        chk("v5_sum",     bus.out_sum,   32'h0000_0005);
        chk("v5_ovf",     bus.out_ovf,   1'b0);
        drain();

        // Three-operand accumulation; partial sum visible after a non-last op
        send(16'h1234, 1'b0);
        repeat (2) @(negedge clk);
        chk("part_sum",   bus.out_sum,   32'h0000_1234);
        chk("part_valid", bus.out_valid, 1'b0);
        send(16'h0001, 1'b0);
        send(16'hFFFF, 1'b1);
        wait_result();
        chk("v3_sum", bus.out_sum, 32'h0001_1234);
        chk("v3_ovf", bus.out_ovf, 1'b0);
        drain();

        // Lane carry propagation
        send(16'hFFFF, 1'b0);
        send(16'h0001, 1'b1);
        wait_result();
        chk("carry_sum", bus.out_sum, 32'h0001_0000);
        chk("carry_ovf", bus.out_ovf, 1'b0);
        drain();

        // Backpressure in RESULT; in_valid held with changing data is ignored
        send(16'hABCD, 1'b1);
        wait_result();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h7000 + 16'(i);
            bus.in_last  = 1'b1;
            #1;
            chk("hold_sum",   bus.out_sum,   32'h0000_ABCD);
            chk("hold_ready", bus.in_ready,  1'b0);
            chk("hold_valid", bus.out_valid, 1'b1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        drain();
        @(negedge clk);
        chk("hold_noconsume", bus.out_sum, 32'h0);

        // clear while holding a result
        send(16'h0042, 1'b1);
        wait_result();
        bus.clear = 1'b1;
        #1;
        chk("clrres_valid", bus.out_valid, 1'b0);
        chk("clrres_ready", bus.in_ready,  1'b0);
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clrres_sum",   bus.out_sum,   32'h0);
        chk("clrres_after", bus.out_valid, 1'b0);

        // clear in ADD_HI discards the in-flight operand
        send(16'h0100, 1'b1);
        @(negedge clk);
        chk("addhi_lo_written", bus.out_sum, 32'h0000_0100);
        bus.clear = 1'b1;
        #1;
        chk("clrhi_ready", bus.in_ready,  1'b0);
        chk("clrhi_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clrhi_sum", bus.out_sum, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("clrhi_novalid", bus.out_valid, 1'b0);
            @(negedge clk);
        end
        send(16'h0003, 1'b1);
        wait_result();
        chk("clrhi_v3_sum", bus.out_sum, 32'h0000_0003);
        chk("clrhi_v3_ovf", bus.out_ovf, 1'b0);
        drain();

        // Reset pulse in ADD_LO discards the partial sum
        send(16'h0200, 1'b0);
        repeat (2) @(negedge clk);
        send(16'h0300, 1'b1);
        chk("rstlo_pre_sum", bus.out_sum, 32'h0000_0200);
        rst_n = 1'b0;
        #1;
        chk("rstlo_sum",   bus.out_sum,   32'h0);
        chk("rstlo_ready", bus.in_ready,  1'b0);
        chk("rstlo_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstlo_rel_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstlo_novalid", bus.out_valid, 1'b0);
        end
        send(16'h0003, 1'b1);
        wait_result();
        chk("rstlo_v3_sum", bus.out_sum, 32'h0000_0003);
        drain();

        // 65537 x 0xFFFF = 0xFFFF_FFFF, then +1 wraps to zero with overflow
        for (int i = 0; i < 65537; i++) begin
            send(16'hFFFF, 1'b0);
        end
        repeat (2) @(negedge clk);
        chk("full_sum",   bus.out_sum,   32'hFFFF_FFFF);
        chk("full_ovf",   bus.out_ovf,   1'b0);
        chk("full_valid", bus.out_valid, 1'b0);
        send(16'h0001, 1'b1);
        wait_result();
        chk("wrap_sum", bus.out_sum, 32'h0000_0000);
        chk("wrap_ovf", bus.out_ovf, 1'b1);
        drain();
        send(16'h0002, 1'b1);
        wait_result();
        chk("post_wrap_sum", bus.out_sum, 32'h0000_0002);
        chk("post_wrap_ovf", bus.out_ovf, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule : tb_ks_accum32
`default_nettype wire

// File: doc/ks_accum32.md
KS_ACCUM32 -- requirements
Module: ks_accum32

Interface
REQ-001 SHALL have parameter N, default 16, meaning adder lane width in bits.
REQ-002 SHALL have parameter ACC_W, default 2*N (32), meaning accumulator width; only ACC_W = 2*N is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the upstream operand is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an operand this cycle.
REQ-007 SHALL have port in_data, input, N, meaning the unsigned operand.
REQ-008 SHALL have port in_last, input, 1, meaning the operand ends the current accumulation.
REQ-009 SHALL have port clear, input, 1, a synchronous abort that zeroes the accumulator.
REQ-010 SHALL have port out_valid, output, 1, meaning a result is held.
REQ-011 SHALL have port out_ready, input, 1, meaning downstream takes the result.
REQ-012 SHALL have port out_sum, output, ACC_W, the accumulated unsigned sum.
REQ-013 SHALL have port out_ovf, output, 1, the sticky carry-out of the top lane.

Function
REQ-014 SHALL use FSM states IDLE, ADD_LO, ADD_HI and RESULT.
REQ-015 in_ready SHALL be 1 only in IDLE with clear=0; a transfer occurs when in_valid&in_ready, registering in_data and in_last and moving to ADD_LO.
REQ-016 ADD_LO SHALL compute acc[N-1:0]+opnd with Cin=0 through the single adder, write the low lane and register carry c_lo, then move to ADD_HI.
REQ-017 ADD_HI SHALL compute acc[ACC_W-1:N]+0 with Cin=c_lo through the same adder and write the high lane.
REQ-018 ADD_HI SHALL OR the adder carry-out into ovf; wrap-around modulo 2^ACC_W is kept.
REQ-019 ADD_HI SHALL go to RESULT if last_q=1, else to IDLE.
REQ-020 Throughput SHALL be one operand per 3 cycles.
REQ-021 out_valid SHALL rise 3 cycles after the accepting edge of a last operand.
REQ-022 In RESULT, out_valid SHALL be 1, and out_sum/out_ovf SHALL stay stable until out_valid&out_ready.
REQ-023 On out_valid&out_ready, the block SHALL zero acc and ovf and return to IDLE; the next operand is accepted no earlier than the following cycle.
REQ-024 clear=1 SHALL take priority over every transition in every state: next state IDLE, acc=0, ovf=0, out_valid=0, in_ready=0 in that cycle, and any in-flight operand discarded.
REQ-025 out_sum SHALL always equal the registered acc; it is valid to sample only when out_valid=1.
REQ-026 An in_valid held while in_ready=0 SHALL NOT be consumed, and in_data may change freely then.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, acc=0, ovf=0, opnd=0, c_lo=0 and last_q=0, regardless of clk.
REQ-028 During reset, out_valid SHALL be 0 and in_ready SHALL be 0; after release, in_ready SHALL be 1 on the first cycle.
REQ-029 Reset mid-operation SHALL discard the partial sum with no output produced.

Structure
REQ-030 Package ks_pkg SHALL hold N, ACC_W and the FSM state enum.
REQ-031 The block SHALL instantiate exactly one existing 16-bit Kogge-Stone adder, Kogge, with its operands and carry-in muxed by state.
REQ-032 No other adder SHALL be used, and the accumulator SHALL be the only wide register.

Verification
REQ-033 Single last operand 0x0005 from reset SHALL give out_sum=0x0000_0005, out_ovf=0, with out_valid 3 cycles after acceptance.
REQ-034 Operands 0x1234, 0x0001, then 0xFFFF(last) SHALL give out_sum=0x0001_1234, out_ovf=0.
REQ-035 Operands 0xFFFF and 0x0001(last) SHALL give out_sum=0x0001_0000, proving the lane carry.
REQ-036 65537 operands of 0xFFFF then 0x0001(last) SHALL give out_sum=0x0000_0000 and out_ovf=1.
REQ-037 With out_ready=0 for 5 cycles in RESULT, out_sum SHALL stay stable and in_ready=0; out_ready=1 SHALL then give IDLE next cycle with acc=0.
REQ-038 clear pulsed in ADD_HI, and rst_n pulsed in ADD_LO on a separate run, SHALL each leave no out_valid; a following last operand 0x0003 SHALL give out_sum=0x0000_0003.
